fifo_ram_wr_arbiter: RTL and testbench

FIFO_RAM_WR_ARBITER -- requirements
Module: fifo_ram_wr_arbiter

---
 rtl/fifo_ram_wr_arbiter_pkg.sv | 19 +
 rtl/fifo_ram_wr_arbiter_rr_multi_grant.sv | 53 +++++
 rtl/fifo_ram_wr_arbiter.sv | 88 ++++++++
 tb/tb_fifo_ram_wr_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_ram_wr_arbiter_pkg.sv
// Types and width helpers shared by the write arbiter and fifo_ram.
package fifo_ram_wr_arbiter_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Guards against a zero-width pointer when the RAM has a single entry.
  function automatic int calc_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEFAULT_PTR_WIDTH = calc_ptr_width(DEFAULT_FIFO_DEPTH);

  typedef struct packed {
    logic [DEFAULT_PTR_WIDTH-1:0]  addr;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/fifo_ram_wr_arbiter_rr_multi_grant.sv
// Rotating-priority search granting up to N_PORTS requesters per cycle,
// skipping any requester whose address matches an earlier grant.
module rr_multi_grant
  import fifo_ram_wr_arbiter_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int N_PORTS    = 2,
  parameter  int ADDR_WIDTH = 3,
  localparam int IDX_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                               enable,
  input  logic [IDX_WIDTH-1:0]               start,
  input  logic [N_REQ-1:0]                   valid,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]   addr,
  output logic [N_REQ-1:0]                   grant,
  output logic [N_PORTS-1:0][N_REQ-1:0]      port_grant,
  output logic                               any_grant,
  output logic [IDX_WIDTH-1:0]               last_idx
);

  // Outer loop walks scan positions; the inner loop finds the requester sitting
  // at that position so every array index stays a loop constant.
  always_comb begin
    int  count;
    logic conflict;
    grant      = '0;
    port_grant = '0;
    any_grant  = 1'b0;
    last_idx   = start;
    count      = 0;
    conflict   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (((i + N_REQ - int'(start)) % N_REQ) == k) begin
          conflict = 1'b0;
          for (int j = 0; j < N_REQ; j++) begin
            if (grant[j] && (addr[j] == addr[i])) conflict = 1'b1;
          end
          if (enable && valid[i] && (count < N_PORTS) && !conflict) begin
            grant[i] = 1'b1;
            for (int p = 0; p < N_PORTS; p++) begin
              if (p == count) port_grant[p][i] = 1'b1;
            end
            count     = count + 1;
            any_grant = 1'b1;
            last_idx  = IDX_WIDTH'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/fifo_ram_wr_arbiter.sv
// Arbitrates write-back requesters onto the fifo_ram write ports with a
// rotating priority and a one-cycle registered output stage.
module fifo_ram_wr_arbiter
  import fifo_ram_wr_arbiter_pkg::*;
#(
  parameter  int N_REQ         = 4,
  parameter  int N_WRITE_PORTS = 2,
  parameter  int DATA_WIDTH    = 32,
  parameter  int FIFO_DEPTH    = 8,
  localparam int PTR_WIDTH     = calc_ptr_width(FIFO_DEPTH),
  localparam int RR_WIDTH      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       stall,
  input  logic                                       flush,
  input  logic [N_REQ-1:0]                           req_valid,
  input  logic [N_REQ-1:0][PTR_WIDTH-1:0]            req_addr,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]           req_data,
  output logic [N_REQ-1:0]                           req_ready,
  output logic [N_WRITE_PORTS-1:0]                   wr_en,
  output logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]    wr_addr,
  output logic [N_WRITE_PORTS-1:0][DATA_WIDTH-1:0]   wr_data,
  output logic [RR_WIDTH-1:0]                        rr_ptr
);

  logic                                     grant_en;
  logic [N_WRITE_PORTS-1:0][N_REQ-1:0]      port_grant;
  logic                                     any_grant;
  logic [RR_WIDTH-1:0]                      last_idx;
  logic [RR_WIDTH-1:0]                      next_rr_ptr;
  logic [N_WRITE_PORTS-1:0]                 next_en;
  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]  next_addr;
  logic [N_WRITE_PORTS-1:0][DATA_WIDTH-1:0] next_data;

  assign grant_en = !rst && !stall && !flush;

  rr_multi_grant #(
    .N_REQ      (N_REQ),
    .N_PORTS    (N_WRITE_PORTS),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_rr_multi_grant (
    .enable     (grant_en),
    .start      (rr_ptr),
    .valid      (req_valid),
    .addr       (req_addr),
    .grant      (req_ready),
    .port_grant (port_grant),
    .any_grant  (any_grant),
    .last_idx   (last_idx)
  );

  // Priority moves just past the last winner; idle ports mux to zero so the
  // write bus never carries X.
  always_comb begin
    next_rr_ptr = rr_ptr;
    if (any_grant) begin
      next_rr_ptr = (int'(last_idx) == N_REQ - 1) ? '0 : last_idx + RR_WIDTH'(1);
    end
    next_en   = '0;
    next_addr = '0;
    next_data = '0;
    for (int p = 0; p < N_WRITE_PORTS; p++) begin
      next_en[p] = |port_grant[p];
      for (int i = 0; i < N_REQ; i++) begin
        if (port_grant[p][i]) begin
          next_addr[p] = next_addr[p] | req_addr[i];
          next_data[p] = next_data[p] | req_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      rr_ptr  <= '0;
    end else begin
      wr_en   <= next_en;
      wr_addr <= next_addr;
      wr_data <= next_data;
      rr_ptr  <= next_rr_ptr;
    end
  end

endmodule

// File: tb/tb_fifo_ram_wr_arbiter.sv
// Directed scoreboard bench for fifo_ram_wr_arbiter plus a short random
// phase checking grant legality, port address uniqueness and starvation bound.
module tb_fifo_ram_wr_arbiter;
  import fifo_ram_wr_arbiter_pkg::*;

  localparam int N_REQ = 4;
  localparam int N_WP  = 2;
  localparam int DW    = 32;
  localparam int AW    = 3;

  typedef struct {
    int      cyc;
    int      port;
    wr_req_t req;
  } exp_t;

  logic                      clk;
  logic                      rst;
  logic                      stall;
  logic                      flush;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0][AW-1:0]  req_addr;
  logic [N_REQ-1:0][DW-1:0]  req_data;
  logic [N_REQ-1:0]          req_ready;
  logic [N_WP-1:0]           wr_en;
  logic [N_WP-1:0][AW-1:0]   wr_addr;
  logic [N_WP-1:0][DW-1:0]   wr_data;
  logic [1:0]                rr_ptr;

  int   cyc;
  int   n_cmp;
  int   n_bad;
  logic sb_active;
  exp_t sb[$];

  localparam logic [3:0][2:0] A1234 = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [3:0][2:0] A55   = {3'd0, 3'd0, 3'd5, 3'd5};
  localparam logic [3:0][2:0] A6    = {3'd0, 3'd6, 3'd0, 3'd0};
  localparam logic [3:0][2:0] A7727 = {3'd7, 3'd2, 3'd7, 3'd7};

  fifo_ram_wr_arbiter #(
    .N_REQ(N_REQ), .N_WRITE_PORTS(N_WP), .DATA_WIDTH(DW), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rr_ptr(rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Expected writes are derived from the hand-written grant vector and rr_ptr.
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [3:0][2:0] a,
                               input logic [23:0] base, input logic s, input logic f,
                               input logic [3:0] exp_ready, input logic [1:0] exp_ptr,
                               input logic [1:0] exp_wr);
    int k;
    int i;
    exp_t e;
    @(negedge clk);
    rst   = r;
    stall = s;
    flush = f;
    req_valid = v;
    req_addr  = a;
    for (int n = 0; n < N_REQ; n++) req_data[n] = {base, 8'(n)};
    #1;
    checkOutput("rr_ptr", 64'(rr_ptr), 64'(exp_ptr));
    checkOutput("wr_en", 64'(wr_en), 64'(exp_wr));
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    k = 0;
    for (int n = 0; n < N_REQ; n++) begin
      i = (int'(exp_ptr) + n) % N_REQ;
      if (exp_ready[i]) begin
        e.cyc      = cyc + 1;
        e.port     = k;
        e.req.addr = a[i];
        e.req.data = {base, 8'(i)};
        sb.push_back(e);
        k++;
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (&wr_en) checkOutput("wr_addr_distinct", 64'(wr_addr[0] == wr_addr[1]), 64'(0));
      if (sb_active) begin
        for (int p = 0; p < N_WP; p++) begin
          if (wr_en[p]) begin
            if (sb.size() == 0) begin
              checkOutput("sb_unexpected_wr_en", 64'(wr_en[p]), 64'(0));
            end else begin
              e = sb.pop_front();
              checkOutput("sb_port_cycle", {32'(p), 32'(cyc)}, {32'(e.port), 32'(e.cyc)});
              checkOutput("sb_wr_addr", 64'(wr_addr[p]), 64'(e.req.addr));
              checkOutput("sb_wr_data", 64'(wr_data[p]), 64'(e.req.data));
            end
          end
        end
      end
    end
  end

  initial begin
    logic [3:0]     pend;
    logic [3:0]     granted_last;
    int             waitc [N_REQ];
    cyc = 0; n_cmp = 0; n_bad = 0; sb_active = 1'b1;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    $display("[TB] directed phase");
    //            rst  valid    addr   base      st    fl    ready    ptr    wr
    applyStimulus(1'b1, 4'b1111, A1234, 24'h0001, 1'b0, 1'b0, 4'b0000, 2'd0, 2'b00);
    applyStimulus(1'b0, 4'b1111, A1234, 24'h0002, 1'b0, 1'b0, 4'b0011, 2'd0, 2'b00);
    applyStimulus(1'b0, 4'b1111, A1234, 24'h0003, 1'b0, 1'b0, 4'b1100, 2'd2, 2'b11);
    applyStimulus(1'b0, 4'b1111, A1234, 24'h0004, 1'b0, 1'b0, 4'b0011, 2'd0, 2'b11);
    applyStimulus(1'b0, 4'b1111, A1234, 24'h0005, 1'b0, 1'b0, 4'b1100, 2'd2, 2'b11);
    applyStimulus(1'b0, 4'b1111, A1234, 24'h0006, 1'b1, 1'b0, 4'b0000, 2'd0, 2'b11);
    applyStimulus(1'b0, 4'b1111, A1234, 24'h0006, 1'b1, 1'b0, 4'b0000, 2'd0, 2'b00);
    applyStimulus(1'b0, 4'b1111, A1234, 24'h0006, 1'b1, 1'b0, 4'b0000, 2'd0, 2'b00);
    applyStimulus(1'b0, 4'b1111, A1234, 24'h0006, 1'b0, 1'b0, 4'b0011, 2'd0, 2'b00);
    applyStimulus(1'b0, 4'b1000, A1234, 24'h0007, 1'b0, 1'b0, 4'b1000, 2'd2, 2'b11);
    applyStimulus(1'b0, 4'b0011, A55,   24'h0008, 1'b0, 1'b0, 4'b0001, 2'd0, 2'b01);
    applyStimulus(1'b0, 4'b0010, A55,   24'h0008, 1'b0, 1'b0, 4'b0010, 2'd1, 2'b01);
    applyStimulus(1'b0, 4'b0100, A6,    24'h0009, 1'b0, 1'b0, 4'b0100, 2'd2, 2'b01);
    applyStimulus(1'b0, 4'b1111, A1234, 24'h000A, 1'b0, 1'b1, 4'b0000, 2'd3, 2'b01);
    applyStimulus(1'b0, 4'b0000, A1234, 24'h000B, 1'b0, 1'b0, 4'b0000, 2'd3, 2'b00);
    applyStimulus(1'b0, 4'b1111, A7727, 24'h000C, 1'b0, 1'b0, 4'b1100, 2'd3, 2'b00);
    applyStimulus(1'b0, 4'b0011, A7727, 24'h000C, 1'b0, 1'b0, 4'b0001, 2'd3, 2'b11);
    applyStimulus(1'b0, 4'b0010, A7727, 24'h000C, 1'b0, 1'b0, 4'b0010, 2'd1, 2'b01);
    applyStimulus(1'b0, 4'b0001, A1234, 24'h000D, 1'b0, 1'b0, 4'b0001, 2'd2, 2'b01);
    applyStimulus(1'b1, 4'b1111, A1234, 24'h000E, 1'b0, 1'b0, 4'b0000, 2'd1, 2'b01);
    applyStimulus(1'b0, 4'b1111, A1234, 24'h000F, 1'b0, 1'b0, 4'b0011, 2'd0, 2'b00);
    applyStimulus(1'b0, 4'b0000, A1234, 24'h0010, 1'b0, 1'b0, 4'b0000, 2'd2, 2'b11);
    applyStimulus(1'b0, 4'b0000, A1234, 24'h0011, 1'b0, 1'b0, 4'b0000, 2'd2, 2'b00);
    @(posedge clk);
    #2;
    sb_active = 1'b0;
    checkOutput("sb_leftover", 64'(sb.size()), 64'(0));

    $display("[TB] random phase");
    pend = '0;
    granted_last = '0;
    for (int n = 0; n < N_REQ; n++) waitc[n] = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      for (int n = 0; n < N_REQ; n++) begin
        if (pend[n] && granted_last[n]) pend[n] = 1'b0;
        if (!pend[n] && ($urandom_range(1, 0) == 1)) begin
          pend[n]     = 1'b1;
          waitc[n]    = 0;
          req_addr[n] = {2'(n), 1'($urandom_range(1, 0))};
          req_data[n] = $urandom();
        end
      end
      req_valid = pend;
      stall = ($urandom_range(7, 0) == 0);
      flush = ($urandom_range(9, 0) == 0);
      #1;
      checkOutput("ready_without_valid", 64'(req_ready & ~req_valid), 64'(0));
      if (stall || flush) checkOutput("ready_while_blocked", 64'(req_ready), 64'(0));
      for (int n = 0; n < N_REQ; n++) begin
        granted_last[n] = pend[n] && req_ready[n];
        if (pend[n] && !req_ready[n] && !stall && !flush) begin
          waitc[n]++;
          checkOutput("starve_bound", 64'(waitc[n] < N_REQ), 64'(1));
        end
      end
    end
    @(negedge clk);
    req_valid = '0;
    stall = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
